// File: rtl/csr_hpm_counters_pkg.sv
// CSR address/op definitions shared by the counter bank and its neighbours.
// Optional feature macro used by this slice: HPM_OVERFLOW_IRQ_EN.
package libcsr;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MHPMEVENT3    = 12'h323,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MHPMCOUNTER3  = 12'hB03,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_MHPMCOUNTER3H = 12'hB83
    } csr_add_e;

    // Overflow flag position inside mhpmeventN
    localparam int MHPM_EVT_OF_BIT = 31;

    // Event selector held in mhpmeventN[7:0]
    typedef logic [7:0] hpm_evt_t;

    // Bit n set when counter n exists: mcycle (0), minstret (2), mhpmcounter3..3+num_hpm-1
    function automatic logic [31:0] counter_mask(input int num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int i = 3; i < 32; i++) begin
            if (i < 3 + num_hpm) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/csr_hpm_counters_counter.sv
// Single CNT_W-bit counter with independent low/high 32-bit write ports.
// A write to either half suppresses that cycle's increment; the untouched
// half keeps its value. wrap flags the edge on which an increment rolls to 0.
module hpm_counter #(
    parameter int CNT_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc_en,
    input  logic               wr_lo,
    input  logic               wr_hi,
    input  logic [31:0]        lo_wdata,
    input  logic [CNT_W-33:0]  hi_wdata,
    output logic [CNT_W-1:0]   value,
    output logic               wrap
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Next value: software write beats increment
    always_comb begin
        cnt_next = cnt_reg;
        if (wr_lo) begin
            cnt_next[31:0] = lo_wdata;
        end else if (wr_hi) begin
            cnt_next[CNT_W-1:32] = hi_wdata;
        end else if (inc_en) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign value = cnt_reg;
    assign wrap  = inc_en & ~wr_lo & ~wr_hi & (&cnt_reg);

endmodule

// File: rtl/csr_hpm_counters.sv
// Machine counter/timer CSR bank: mcycle, minstret and NUM_HPM mhpmcounters,
// with mcountinhibit and per-counter event selection.
// Define HPM_OVERFLOW_IRQ_EN to add sticky overflow flags (mhpmeventN[31])
// and the overflow interrupt; otherwise irq_o is tied low.
module csr_hpm_counters
    import libcsr::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int CNT_W      = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [11:0]           csr_addr_i,
    input  logic [1:0]            csr_op_i,
    input  logic                  csr_valid_i,
    input  logic [31:0]           csr_wdata_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    input  logic                  stall_i,
    input  logic                  retire_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  irq_o
);

    localparam logic [31:0] CNT_MASK = counter_mask(NUM_HPM);
    localparam logic [11:0] ADDR_LO  = CSR_MCYCLE;
    localparam logic [11:0] ADDR_HI  = CSR_MCYCLEH;
    localparam logic [11:0] ADDR_INH = CSR_MCOUNTINHIBIT;

    logic [4:0]        idx;
    logic              sel_lo;
    logic              sel_hi;
    logic              sel_inh;
    logic              sel_evt;
    logic              we;
    logic [31:0]       wd;
    logic [31:0]       inh_reg;
    logic [31:0][31:0] lo_rd;
    logic [31:0][31:0] hi_rd;
    logic [31:0][31:0] evt_rd;

    // Address decode: index within a 32-entry page selects the counter
    assign idx     = csr_addr_i[4:0];
    assign sel_lo  = (csr_addr_i[11:5] == ADDR_LO[11:5]) && CNT_MASK[idx];
    assign sel_hi  = (csr_addr_i[11:5] == ADDR_HI[11:5]) && CNT_MASK[idx];
    assign sel_inh = (csr_addr_i == ADDR_INH);
    assign sel_evt = (csr_addr_i[11:5] == ADDR_INH[11:5]) && (idx >= 5'd3) && CNT_MASK[idx];
    assign csr_hit_o = sel_lo | sel_hi | sel_inh | sel_evt;

    // Read mux on pre-edge state; also the operand of SET/CLEAR
    always_comb begin
        csr_rdata_o = '0;
        if (sel_lo) begin
            csr_rdata_o = lo_rd[idx];
        end else if (sel_hi) begin
            csr_rdata_o = hi_rd[idx];
        end else if (sel_inh) begin
            csr_rdata_o = inh_reg;
        end else if (sel_evt) begin
            csr_rdata_o = evt_rd[idx];
        end
    end

    // Write data for the read-modify-write ops
    always_comb begin
        case (csr_op_e'(csr_op_i))
            CSR_OP_SET:   wd = csr_rdata_o | csr_wdata_i;
            CSR_OP_CLEAR: wd = csr_rdata_o & ~csr_wdata_i;
            default:      wd = csr_wdata_i;
        endcase
    end

    assign we = csr_valid_i & ~stall_i & (csr_op_i != CSR_OP_READ) & csr_hit_o;

    // mcountinhibit: only bits of existing counters are writable
    always_ff @(posedge clk) begin
        if (rst) begin
            inh_reg <= '0;
        end else if (we && sel_inh) begin
            inh_reg <= wd & CNT_MASK;
        end
    end

`ifdef HPM_OVERFLOW_IRQ_EN
    logic [31:0] of_next;
    logic        irq_reg;

    // Interrupt tracks the OF flags as they are updated on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |of_next;
        end
    end

    assign irq_o = irq_reg;
`else
    assign irq_o = 1'b0;
`endif

    for (genvar gi = 0; gi < 32; gi++) begin : g_slot
        if (CNT_MASK[gi]) begin : g_cnt
            logic             inc_en;
            logic             wr_lo;
            logic             wr_hi;
            logic [CNT_W-1:0] value;
            logic             wrap;

            assign wr_lo = we & sel_lo & (idx == 5'(gi));
            assign wr_hi = we & sel_hi & (idx == 5'(gi));

            hpm_counter #(
                .CNT_W (CNT_W)
            ) u_counter (
                .clk      (clk),
                .rst      (rst),
                .inc_en   (inc_en),
                .wr_lo    (wr_lo),
                .wr_hi    (wr_hi),
                .lo_wdata (wd),
                .hi_wdata (wd[CNT_W-33:0]),
                .value    (value),
                .wrap     (wrap)
            );

            assign lo_rd[gi] = value[31:0];
            assign hi_rd[gi] = 32'(value[CNT_W-1:32]);

            if (gi == 0) begin : g_mcycle
                logic wrap_unused;
                assign inc_en      = ~inh_reg[0];
                assign evt_rd[gi]  = '0;
                assign wrap_unused = wrap;
`ifdef HPM_OVERFLOW_IRQ_EN
                assign of_next[gi] = 1'b0;
`endif
            end else if (gi == 2) begin : g_minstret
                logic wrap_unused;
                assign inc_en      = retire_i & ~stall_i & ~inh_reg[2];
                assign evt_rd[gi]  = '0;
                assign wrap_unused = wrap;
`ifdef HPM_OVERFLOW_IRQ_EN
                assign of_next[gi] = 1'b0;
`endif
            end else begin : g_hpm
                hpm_evt_t evt_reg;
                logic     fire;

                // Selected event strobe; selector 0 or beyond NUM_EVENTS never fires
                always_comb begin
                    fire = 1'b0;
                    for (int e = 0; e < NUM_EVENTS; e++) begin
                        if (evt_reg == hpm_evt_t'(e + 1)) begin
                            fire = event_i[e];
                        end
                    end
                end

                assign inc_en = fire & ~inh_reg[gi];

                // Event selector register
                always_ff @(posedge clk) begin
                    if (rst) begin
                        evt_reg <= '0;
                    end else if (we && sel_evt && (idx == 5'(gi))) begin
                        evt_reg <= wd[7:0];
                    end
                end

`ifdef HPM_OVERFLOW_IRQ_EN
                logic of_reg;

                // A wrap on the same edge as a software write still latches OF
                always_comb begin
                    of_next[gi] = of_reg;
                    if (we && sel_evt && (idx == 5'(gi))) begin
                        of_next[gi] = wd[MHPM_EVT_OF_BIT];
                    end
                    if (wrap) begin
                        of_next[gi] = 1'b1;
                    end
                end

                // Sticky overflow flag
                always_ff @(posedge clk) begin
                    if (rst) begin
                        of_reg <= 1'b0;
                    end else begin
                        of_reg <= of_next[gi];
                    end
                end

                assign evt_rd[gi] = {of_reg, 23'b0, evt_reg};
`else
                logic wrap_unused;
                assign wrap_unused = wrap;
                assign evt_rd[gi]  = {24'b0, evt_reg};
`endif
            end
        end else begin : g_none
            assign lo_rd[gi]  = '0;
            assign hi_rd[gi]  = '0;
            assign evt_rd[gi] = '0;
`ifdef HPM_OVERFLOW_IRQ_EN
            assign of_next[gi] = 1'b0;
`endif
        end
    end

endmodule
